fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: request/response wrapper around a fixed-latency FPU core with an in-order result FIFO.
// Optional sticky exception register: define FPU_ISSUE_EXC_STICKY_EN to add exc_clr/exc_sticky.
module fpu_issue_ctrl #(
   parameter int DEPTH = 4,
   parameter int LAT   = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_rmode,
   input  logic [2:0]       req_op,
   input  logic [31:0]      req_opa,
   input  logic [31:0]      req_opb,
   input  logic [TAG_W-1:0] req_tag,
   output logic [1:0]       fpu_rmode,
   output logic [2:0]       fpu_op,
   output logic [31:0]      fpu_opa,
   output logic [31:0]      fpu_opb,
   input  logic [31:0]      fpu_out,
   input  logic [7:0]       fpu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_out,
   output logic [7:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
`ifdef FPU_ISSUE_EXC_STICKY_EN
   input  logic             exc_clr,
   output logic [7:0]       exc_sticky,
`endif
   output logic             busy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [LAT-1:0]   pipe_v;
   logic [TAG_W-1:0] pipe_tag [LAT];
   logic [31:0]      mem_out   [DEPTH];
   logic [7:0]       mem_flags [DEPTH];
   logic [TAG_W-1:0] mem_tag   [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] fifo_count, outstanding;
   logic             accept, push, pop;

   // Admission counts in-flight plus buffered work, so a pipeline exit always finds a free FIFO slot.
   assign accept    = req_valid & req_ready;
   assign push      = pipe_v[LAT-1];
   assign pop       = rsp_valid & rsp_ready;
   assign req_ready = ~rst & (outstanding < CNT_W'(DEPTH));
   assign busy      = (outstanding != '0);
   assign rsp_valid = (fifo_count != '0);
   assign rsp_out   = rsp_valid ? mem_out[rd_ptr]   : '0;
   assign rsp_flags = rsp_valid ? mem_flags[rd_ptr] : '0;
   assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr]   : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpu_rmode <= '0;
         fpu_op    <= '0;
         fpu_opa   <= '0;
         fpu_opb   <= '0;
      end else if (accept) begin
         fpu_rmode <= req_rmode;
         fpu_op    <= req_op;
         fpu_opa   <= req_opa;
         fpu_opb   <= req_opb;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
         for (int unsigned i = 0; i < LAT; i++) pipe_tag[i] <= '0;
      end else begin
         pipe_v[0]   <= accept;
         pipe_tag[0] <= req_tag;
         for (int unsigned i = 1; i < LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_out[wr_ptr]   <= fpu_out;
         mem_flags[wr_ptr] <= fpu_flags;
         mem_tag[wr_ptr]   <= pipe_tag[LAT-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
         case ({accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef FPU_ISSUE_EXC_STICKY_EN
   // A FIFO write on the clearing edge keeps its own flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          exc_sticky <= '0;
      else if (exc_clr) exc_sticky <= push ? fpu_flags : '0;
      else if (push)    exc_sticky <= exc_sticky | fpu_flags;
   end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl (DEPTH=4, LAT=4) with a stand-in fixed-latency FPU core.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
   localparam int DEPTH = 4;
   localparam int LAT   = 4;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [1:0]       rmode;
      logic [2:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
   } req_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid, req_ready, rsp_valid, rsp_ready, busy;
   logic [1:0]       req_rmode, fpu_rmode;
   logic [2:0]       req_op, fpu_op;
   logic [31:0]      req_opa, req_opb, fpu_opa, fpu_opb, fpu_out, rsp_out;
   logic [7:0]       fpu_flags, rsp_flags;
   logic [TAG_W-1:0] req_tag, rsp_tag;
`ifdef FPU_ISSUE_EXC_STICKY_EN
   logic             exc_clr = 1'b0;
   logic [7:0]       exc_sticky;
`endif

   int compared   = 0;
   int mismatched = 0;
   logic [43:0] exp_q [$];

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rmode(req_rmode), .req_op(req_op), .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
      .fpu_rmode(fpu_rmode), .fpu_op(fpu_op), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
      .fpu_out(fpu_out), .fpu_flags(fpu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
`ifdef FPU_ISSUE_EXC_STICKY_EN
      .exc_clr(exc_clr), .exc_sticky(exc_sticky),
`endif
      .busy(busy)
   );

   // Stand-in core: known IEEE cases, otherwise an arbitrary deterministic mix.
   function automatic logic [39:0] core_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h3F80_0000) return {32'h4000_0000, 8'h00};
      if (op == 3'd3 && b == 32'h0 && a != 32'h0) return {32'h7F80_0000, 8'h81};
      return {a ^ {b[15:0], b[31:16]} ^ {29'd0, op}, a[7:0] ^ b[7:0]};
   endfunction

   // Result of fpu_* registered at edge T is sampled by the controller at edge T+LAT.
   logic [39:0] core_pipe [LAT-1];
   always @(posedge clk) begin
      core_pipe[0] <= core_fn(fpu_op, fpu_opa, fpu_opb);
      for (int i = 1; i < LAT-1; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign {fpu_out, fpu_flags} = core_pipe[LAT-2];

   function automatic req_t item(input int n);
      req_t r;
      r.rmode = 2'(n);
      r.op    = 3'(n % 3);
      r.a     = 32'h4000_0000 + 32'(n) * 32'h0001_0203;
      r.b     = 32'h3F00_0000 ^ (32'(n) << 4);
      r.tag   = TAG_W'(n);
      return r;
   endfunction

   function automatic logic [43:0] expect_of(input req_t r);
      return {r.tag, core_fn(r.op, r.a, r.b)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input req_t r);
      req_valid = 1'b1;
      req_rmode = r.rmode;
      req_op    = r.op;
      req_opa   = r.a;
      req_opb   = r.b;
      req_tag   = r.tag;
   endtask

   task automatic test_reset();
      req_valid = 1'b0; req_rmode = '0; req_op = '0; req_opa = '0; req_opb = '0; req_tag = '0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      compared++;
      if ({req_ready, rsp_valid, busy} !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_ctrl: {req_ready,rsp_valid,busy} got %b expected 000", {req_ready, rsp_valid, busy});
      end
      compared++;
      if ({fpu_rmode, fpu_op, fpu_opa, fpu_opb, rsp_out, rsp_flags, rsp_tag} !== '0) begin
         mismatched++;
         $display("FAIL reset_data: fpu_opa=%h rsp_out=%h rsp_flags=%h rsp_tag=%h expected all 0", fpu_opa, rsp_out, rsp_flags, rsp_tag);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if ({req_ready, busy} !== 2'b10) begin
         mismatched++;
         $display("FAIL reset_release: {req_ready,busy} got %b expected 10", {req_ready, busy});
      end
`ifdef FPU_ISSUE_EXC_STICKY_EN
      compared++;
      if (exc_sticky !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_sticky: got %h expected 00", exc_sticky);
      end
`endif
   endtask

   task automatic test_single_add();
      req_t r;
      tick();
      r = '{rmode: 2'b01, op: 3'd0, a: 32'h3F80_0000, b: 32'h3F80_0000, tag: 4'h5};
      present(r);
      rsp_ready = 1'b1;
      @(negedge clk);
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL add_req_ready: got %b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) begin
            compared++;
            if ({fpu_rmode, fpu_op, fpu_opa, fpu_opb, busy} !== {2'b01, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 1'b1}) begin
               mismatched++;
               $display("FAIL add_fpu_drive: rmode=%b op=%0d opa=%h opb=%h busy=%b expected 01/0/3f800000/3f800000/1",
                        fpu_rmode, fpu_op, fpu_opa, fpu_opb, busy);
            end
         end
         compared++;
         if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL add_early_rsp: rsp_valid got %b in cycle %0d expected 0", rsp_valid, c);
         end
         tick();
      end
      @(negedge clk);
      compared++;
      if ({rsp_valid, rsp_out, rsp_flags, rsp_tag} !== {1'b1, 32'h4000_0000, 8'h00, 4'h5}) begin
         mismatched++;
         $display("FAIL add_rsp_cycle5: valid=%b out=%h flags=%h tag=%h expected 1/40000000/00/5",
                  rsp_valid, rsp_out, rsp_flags, rsp_tag);
      end
      tick();
      @(negedge clk);
      compared++;
      if ({rsp_valid, busy} !== 2'b00) begin
         mismatched++;
         $display("FAIL add_drained: {rsp_valid,busy} got %b expected 00", {rsp_valid, busy});
      end
   endtask

   task automatic test_div();
      int   wait_c;
      req_t r;
      tick();
      r = '{rmode: 2'b00, op: 3'd3, a: 32'h3F80_0000, b: 32'h0000_0000, tag: 4'h9};
      present(r);
      rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_c = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && wait_c < 20) begin
         wait_c++;
         @(negedge clk);
      end
      compared++;
      if ({rsp_valid, rsp_out, rsp_flags, rsp_tag} !== {1'b1, 32'h7F80_0000, 8'h81, 4'h9}) begin
         mismatched++;
         $display("FAIL div_by_zero: valid=%b out=%h flags=%h tag=%h expected 1/7f800000/81/9",
                  rsp_valid, rsp_out, rsp_flags, rsp_tag);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int acc, got;
      logic [43:0] e;
      tick();
      rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         present(item(acc));
         @(negedge clk);
         compared++;
         if (req_ready !== (c < 4)) begin
            mismatched++;
            $display("FAIL bp_req_ready: cycle %0d got %b expected %b", c, req_ready, (c < 4));
         end
         if (req_valid && req_ready) begin
            exp_q.push_back(expect_of(item(acc)));
            acc++;
         end
         tick();
      end
      compared++;
      if (acc != 4) begin
         mismatched++;
         $display("FAIL bp_accepted: got %0d expected 4", acc);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         compared++;
         if ({rsp_valid, req_ready, busy, rsp_tag, rsp_out, rsp_flags} !== {3'b101, expect_of(item(0))}) begin
            mismatched++;
            $display("FAIL bp_hold: valid=%b ready=%b busy=%b tag=%h out=%h flags=%h expected 1/0/1 %h",
                     rsp_valid, req_ready, busy, rsp_tag, rsp_out, rsp_flags, expect_of(item(0)));
         end
         tick();
      end
      rsp_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 60 && (got < 6 || acc < 6); cyc++) begin
         if (acc < 6) present(item(acc));
         else req_valid = 1'b0;
         @(negedge clk);
         if (req_valid && req_ready) begin
            exp_q.push_back(expect_of(item(acc)));
            acc++;
         end
         if (rsp_valid && rsp_ready) begin
            compared++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            if ({rsp_tag, rsp_out, rsp_flags} !== e) begin
               mismatched++;
               $display("FAIL bp_order: response %0d got tag=%h out=%h flags=%h expected %h", got, rsp_tag, rsp_out, rsp_flags, e);
            end
            got++;
         end
         tick();
      end
      req_valid = 1'b0;
      compared++;
      if (got != 6 || acc != 6) begin
         mismatched++;
         $display("FAIL bp_totals: responses %0d accepts %0d expected 6/6", got, acc);
      end
   endtask

   task automatic test_stream();
      int acc, got, model, max_model, both;
      bit a, p;
      logic [43:0] e;
      tick();
      exp_q.delete();
      acc = 0; got = 0; model = 0; max_model = 0; both = 0;
      for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
         rsp_ready = cyc[0];
         if (acc < 20 && (cyc % 3) != 2) present(item(100 + acc));
         else req_valid = 1'b0;
         @(negedge clk);
         compared++;
         if (req_ready !== (model < 4)) begin
            mismatched++;
            $display("FAIL stream_ready: cycle %0d got %b expected %b (outstanding %0d)", cyc, req_ready, (model < 4), model);
         end
         compared++;
         if (busy !== (model != 0)) begin
            mismatched++;
            $display("FAIL stream_busy: cycle %0d got %b expected %b", cyc, busy, (model != 0));
         end
         a = req_valid && req_ready;
         p = rsp_valid && rsp_ready;
         if (a) begin
            exp_q.push_back(expect_of(item(100 + acc)));
            acc++;
         end
         if (p) begin
            compared++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            if ({rsp_tag, rsp_out, rsp_flags} !== e) begin
               mismatched++;
               $display("FAIL stream_data: response %0d got tag=%h out=%h flags=%h expected %h", got, rsp_tag, rsp_out, rsp_flags, e);
            end
            got++;
         end
         if (a && p) both++;
         model = model + int'(a) - int'(p);
         if (model > max_model) max_model = model;
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      compared++;
      if (got != 20 || acc != 20 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL stream_totals: responses %0d accepts %0d leftover %0d expected 20/20/0", got, acc, exp_q.size());
      end
      compared++;
      if (max_model > 4 || both == 0) begin
         mismatched++;
         $display("FAIL stream_occupancy: max outstanding %0d (limit 4), accept+pop edges %0d (expected >0)", max_model, both);
      end
   endtask

   task automatic test_reset_midop();
      int seen;
      tick();
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         present(item(200 + c));
         tick();
      end
      req_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      compared++;
      if ({rsp_valid, busy} !== 2'b11) begin
         mismatched++;
         $display("FAIL midop_before: {rsp_valid,busy} got %b expected 11", {rsp_valid, busy});
      end
      #1 rst = 1'b1;
      #1;
      compared++;
      if ({req_ready, rsp_valid, busy, rsp_out, rsp_flags, rsp_tag} !== '0) begin
         mismatched++;
         $display("FAIL midop_in_reset: ready=%b valid=%b busy=%b out=%h flags=%h tag=%h expected all 0",
                  req_ready, rsp_valid, busy, rsp_out, rsp_flags, rsp_tag);
      end
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if ({req_ready, rsp_valid, busy} !== 3'b100) begin
         mismatched++;
         $display("FAIL midop_release: {req_ready,rsp_valid,busy} got %b expected 100", {req_ready, rsp_valid, busy});
      end
      rsp_ready = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      compared++;
      if (seen != 0) begin
         mismatched++;
         $display("FAIL midop_ghost_rsp: got %0d response cycles expected 0", seen);
      end
`ifdef FPU_ISSUE_EXC_STICKY_EN
      compared++;
      if (exc_sticky !== 8'h00) begin
         mismatched++;
         $display("FAIL midop_sticky: got %h expected 00", exc_sticky);
      end
`endif
   endtask

`ifdef FPU_ISSUE_EXC_STICKY_EN
   task automatic test_sticky();
      tick();
      rsp_ready = 1'b1;
      present('{rmode: 2'b00, op: 3'd3, a: 32'h3F80_0000, b: 32'h0, tag: 4'h1});
      tick();
      present('{rmode: 2'b00, op: 3'd0, a: 32'h3F80_0000, b: 32'h3F80_0000, tag: 4'h2});
      tick();
      req_valid = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      compared++;
      if (exc_sticky !== 8'h81) begin
         mismatched++;
         $display("FAIL sticky_set: got %h expected 81", exc_sticky);
      end
      repeat (3) tick();
      @(negedge clk);
      compared++;
      if (exc_sticky !== 8'h81) begin
         mismatched++;
         $display("FAIL sticky_hold: got %h expected 81", exc_sticky);
      end
      tick();
      exc_clr = 1'b1;
      tick();
      exc_clr = 1'b0;
      @(negedge clk);
      compared++;
      if (exc_sticky !== 8'h00) begin
         mismatched++;
         $display("FAIL sticky_clear: got %h expected 00", exc_sticky);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_add();
      test_div();
      test_backpressure();
      test_stream();
      test_reset_midop();
`ifdef FPU_ISSUE_EXC_STICKY_EN
      test_sticky();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", compared, mismatched);
      $fatal(1);
   end

endmodule
